// File: rtl/ups_seq_pkg.sv
// Shared types and register-map constants for the UPS step sequencer.
package ups_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} seq_state_t;

  localparam int REG_CTRL   = 0;
  localparam int REG_PERIOD = 1;
  localparam int REG_COUNT  = 2;
  localparam int REG_TABLE  = 3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_STOP    = 1;
  localparam int CTRL_LOOP    = 2;
  localparam int CTRL_IRQ_CLR = 3;

endpackage

// File: rtl/ups_seq_timer.sv
// Loadable down-counter that parks at zero; zero flags the end of a step.
module ups_seq_timer #(
  parameter int TW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          clr,
  input  logic [TW-1:0] load_val,
  output logic          zero
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ups_seq.sv
// Step sequencer: walks the register-bank level table, holding each level PERIOD cycles.
// Optional sticky completion/abort interrupt enabled by defining UPS_SEQ_IRQ_EN.
module ups_seq
  import ups_pkg::*;
#(
  parameter int DW = 8,
  parameter int DI = 3,
  parameter int TW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DW-1:0][31:0]  data,
  input  logic [DW-1:0]        dv,
  output logic [31:0]          seq_out,
  output logic                 seq_stb,
  output logic                 busy,
  output logic                 done,
  output logic [DI-1:0]        step_idx
`ifdef UPS_SEQ_IRQ_EN
  ,
  output logic                 irq
`endif
);

  seq_state_t    state, state_nxt;
  logic [31:0]   ctrl_w;
  logic          cmd_start, cmd_stop, abort;
  logic [TW-1:0] period_w, pm1_in, pm1_q, tmr_val;
  logic [15:0]   n_in, n_q, r_q, pass_q;
  logic          loop_q;
  logic [DI-1:0] idx_q, step_sel, word_sel;
  logic          step_load, pass_inc, tmr_zero, last_step, more_pass;
  logic          ctrl_unused;

  assign ctrl_w    = data[REG_CTRL];
  assign cmd_start = dv[REG_CTRL] & ctrl_w[CTRL_START];
  assign cmd_stop  = dv[REG_CTRL] & ctrl_w[CTRL_STOP];
  assign abort     = cmd_stop & (state != IDLE);

  // A zero period behaves like a one-cycle period; the timer holds P-1.
  assign period_w  = data[REG_PERIOD][TW-1:0];
  assign pm1_in    = (period_w == '0) ? '0 : period_w - TW'(1);
  assign n_in      = (data[REG_COUNT][15:0] > 16'(DW-3)) ? 16'(DW-3) : data[REG_COUNT][15:0];

  assign last_step = (16'(idx_q) + 16'd1) >= n_q;
  assign more_pass = loop_q | (pass_q < r_q);
  assign tmr_val   = (state == LOAD) ? pm1_in : pm1_q;
  assign word_sel  = DI'(REG_TABLE) + step_sel;

  assign ctrl_unused = ^{ctrl_w[31:3], data[REG_PERIOD], dv};

  ups_seq_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (step_load),
    .clr      (abort),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    step_load = 1'b0;
    step_sel  = '0;
    pass_inc  = 1'b0;
    case (state)
      IDLE: if (cmd_start && !cmd_stop) state_nxt = LOAD;
      LOAD: begin
        if (n_in == '0) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
          step_load = 1'b1;
        end
      end
      RUN: begin
        if (tmr_zero) begin
          if (!last_step) begin
            step_load = 1'b1;
            step_sel  = idx_q + DI'(1);
          end else if (more_pass) begin
            step_load = 1'b1;
            pass_inc  = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // STOP overrides any step advance; seq_out keeps its last level.
    if (abort) begin
      state_nxt = IDLE;
      step_load = 1'b0;
      pass_inc  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm1_q   <= '0;
      n_q     <= '0;
      r_q     <= '0;
      loop_q  <= 1'b0;
      idx_q   <= '0;
      pass_q  <= '0;
      seq_out <= '0;
      seq_stb <= 1'b0;
    end else begin
      seq_stb <= step_load;
      if (state == LOAD) begin
        pm1_q  <= pm1_in;
        n_q    <= n_in;
        r_q    <= data[REG_COUNT][31:16];
        loop_q <= ctrl_w[CTRL_LOOP];
        pass_q <= '0;
      end
      if (abort) begin
        idx_q  <= '0;
        pass_q <= '0;
      end else if (step_load) begin
        idx_q   <= step_sel;
        seq_out <= data[word_sel];
        if (pass_inc && pass_q != 16'hFFFF) pass_q <= pass_q + 16'd1;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign step_idx = idx_q;

`ifdef UPS_SEQ_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    irq <= 1'b0;
    else if (done || abort)                        irq <= 1'b1;
    else if (dv[REG_CTRL] && ctrl_w[CTRL_IRQ_CLR]) irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_ups_seq.sv
// Randomized bench for ups_seq: per-cycle comparison against an arithmetic schedule model.
module tb_ups_seq;

  localparam int DW = 8;
  localparam int DI = 3;
  localparam int TW = 32;

  logic                clk;
  logic                rst_n;
  logic [DW-1:0][31:0] data;
  logic [DW-1:0]       dv;
  logic [31:0]         seq_out;
  logic                seq_stb;
  logic                busy;
  logic                done;
  logic [DI-1:0]       step_idx;
`ifdef UPS_SEQ_IRQ_EN
  logic                irq;
`endif

  ups_seq #(.DW(DW), .DI(DI), .TW(TW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .dv       (dv),
    .seq_out  (seq_out),
    .seq_stb  (seq_stb),
    .busy     (busy),
    .done     (done),
    .step_idx (step_idx)
`ifdef UPS_SEQ_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Scenario description consumed by the model.
  int          t0, neff, total, pe, stop_at, model_idx;
  logic [31:0] model_out;
  logic [31:0] tbl [DW-3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Strobe k lands at t0+2+k*P and carries table[k mod N]; done follows the last one by P.
  task automatic check_cycle(input int c);
    int rel, done_c, k;
    bit e_stb, e_done, e_busy;
    rel    = c - t0 - 2;
    done_c = (neff == 0) ? t0 + 2 : t0 + 2 + total * pe;
    e_stb  = (neff > 0) && (rel >= 0) && (rel % pe == 0) && (rel / pe < total) && (c <= stop_at);
    e_done = (c == done_c) && (c <= stop_at);
    e_busy = (c >= t0 + 1) && (c <= done_c) && (c <= stop_at);
    if (e_stb) begin
      k         = rel / pe;
      model_idx = k % neff;
      model_out = tbl[model_idx];
    end
    check("seq_stb", 32'(seq_stb), 32'(e_stb));
    check("done",    32'(done),    32'(e_done));
    check("busy",    32'(busy),    32'(e_busy));
    check("seq_out", seq_out,      model_out);
    if (e_stb) check("step_idx", 32'(step_idx), 32'(model_idx));
  endtask

  task automatic ctrl_write(input logic [31:0] v);
    @(posedge clk); #1;
    data[0] = v;
    dv[0]   = 1'b1;
    @(posedge clk); #1;
    dv = '0;
  endtask

  task automatic run_scn(input int n_raw, input int r, input int p, input bit loop,
                         input int stop_rel, input int start_rel);
    int ncyc;
    for (int i = 0; i < DW - 3; i++) begin
      tbl[i]           = $urandom;
      data[DI'(i + 3)] = tbl[i];
    end
    data[1] = 32'(p);
    data[2] = {16'(r), 16'(n_raw)};
    neff    = (n_raw > DW - 3) ? DW - 3 : n_raw;
    total   = loop ? 1000 : neff * (r + 1);
    pe      = (p == 0) ? 1 : p;
    ncyc    = loop ? stop_rel + 4 : ((neff == 0) ? 2 : 2 + total * pe) + 4;
    @(posedge clk); #1;
    data[0] = loop ? 32'h5 : 32'h1;
    dv[0]   = 1'b1;
    t0      = cyc;
    stop_at = 1 << 30;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      check_cycle(t0 + c);
      @(posedge clk); #1;
      dv = '0;
      if (c + 1 == stop_rel) begin
        data[0] = 32'h2;
        dv[0]   = 1'b1;
        stop_at = t0 + c + 1;
      end
      if (c + 1 == start_rel) begin
        data[0] = 32'h1;
        dv[0]   = 1'b1;
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    data      = '0;
    dv        = '0;
    model_out = '0;
    model_idx = 0;
    stop_at   = 1 << 30;
    #2;
    check("rst_seq_out",  seq_out,          32'h0);
    check("rst_seq_stb",  32'(seq_stb),     32'h0);
    check("rst_busy",     32'(busy),        32'h0);
    check("rst_done",     32'(done),        32'h0);
    check("rst_step_idx", 32'(step_idx),    32'h0);
`ifdef UPS_SEQ_IRQ_EN
    check("rst_irq",      32'(irq),         32'h0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_scn(3, 0, 4, 1'b0, -1, -1);
`ifdef UPS_SEQ_IRQ_EN
    check("irq_after_done", 32'(irq), 32'h1);
    ctrl_write(32'h8);
    check("irq_cleared", 32'(irq), 32'h0);
`endif
    run_scn(3, 0, 4, 1'b0, -1, 6);   // START while running is ignored
    run_scn(2, 1, 0, 1'b0, -1, -1);  // zero period: back-to-back strobes
    run_scn(0, 2, 3, 1'b0, -1, -1);  // empty table: done only
    run_scn(9, 0, 1, 1'b0, -1, -1);  // step count clamped to table size
    for (int i = 0; i < 10; i++)
      run_scn($urandom_range(0, 7), $urandom_range(0, 2), $urandom_range(0, 4), 1'b0, -1, -1);

    run_scn(2, 0, 3, 1'b1, 20, -1);  // looping run aborted by STOP
`ifdef UPS_SEQ_IRQ_EN
    check("irq_after_stop", 32'(irq), 32'h1);
    ctrl_write(32'h8);
    check("irq_cleared2", 32'(irq), 32'h0);
`endif

    // START and STOP in the same write leave the sequencer idle.
    ctrl_write(32'h3);
    for (int i = 0; i < 3; i++) begin
      check("startstop_busy", 32'(busy),    32'h0);
      check("startstop_stb",  32'(seq_stb), 32'h0);
      @(posedge clk); #1;
    end
`ifdef UPS_SEQ_IRQ_EN
    check("startstop_irq", 32'(irq), 32'h0);
`endif

    // Asynchronous reset in the middle of a step.
    data[1] = 32'd4;
    data[2] = 32'd3;
    ctrl_write(32'h1);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_seq_out",  seq_out,       32'h0);
    check("arst_seq_stb",  32'(seq_stb),  32'h0);
    check("arst_busy",     32'(busy),     32'h0);
    check("arst_done",     32'(done),     32'h0);
    check("arst_step_idx", 32'(step_idx), 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    model_out = '0;
    run_scn(3, 0, 4, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ups_seq.md
Name: ups_seq

Overview:
- Step sequencer driven by the UPS AXI4-Lite register bank (data[DW-1:0] 32-bit words plus per-word dv write pulses).
- Register bank holds a control word, a step period, a step/repeat count and an output level table.
- On a start command, walks the table and presents one 32-bit level per step, holding each step for PERIOD cycles, for (R+1) passes.
- Sits between the register bank and the instrument output stage.

Parameters:
- DW, 8, number of 32-bit register words (must be ≥4; table = words 3..DW-1).
- DI, 3, log2(DW); width of step index.
- TW, 32, period timer width (≤32).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, active-low
- data  in  32×DW  register bank words
- dv  in  DW  one-cycle write strobe per word
- seq_out  out  32  current output level
- seq_stb  out  1  one-cycle pulse when seq_out takes a new step value
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at normal completion
- step_idx  out  DI  current table index (0-based)

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). On reset, all outputs are 0, state is IDLE, and all counters are 0.
- Register map:
  - word0 CTRL: bit0 START, bit1 STOP, bit2 LOOP (repeat forever), bit3 IRQ_CLR (see optional feature).
  - word1 PERIOD[TW-1:0]; 0 is treated as 1.
  - word2: [15:0] N steps, clamped to DW-3; [31:16] R extra passes.
  - word k (k≥3): table entry k-3.
- Commands are evaluated only in the cycle dv[0]=1, using data[0] of that cycle. STOP has priority over START in the same write.
- States: IDLE, LOAD, RUN, DONE.
  - IDLE: dv[0]&START&!STOP → LOAD. Other writes are ignored.
  - LOAD, 1 cycle: latch PERIOD (P), N, R, LOOP. If N=0 → DONE with no strobe. Otherwise idx=0, pass=0, seq_out=table[0], seq_stb=1, timer=P-1 → RUN.
  - RUN: timer decrements each cycle. At timer=0:
    - if idx<N-1: idx+1, load table[idx+1], strobe, timer=P-1.
    - else if LOOP or pass<R: pass+1, idx=0, load table[0], strobe, timer=P-1.
    - else → DONE.
  - DONE, 1 cycle: done=1 → IDLE.
- Latency: dv[0] start at cycle t; first seq_stb at t+2; successive strobes exactly P cycles apart; done asserted P cycles after the final strobe.
- Total strobes: N×(R+1) when not looping.
- busy=1 in LOAD, RUN and DONE.
- Table words are read live at each step load. Writes take effect at the next step boundary. PERIOD/N/R writes during a run are ignored until the next start.
- START while busy: ignored.
- STOP in any non-IDLE state: next state is IDLE, no done pulse, seq_out holds its last value, timer/idx cleared.
- pass counter is 16 bits and saturates (cannot wrap, since LOOP is handled separately).
- Reset mid-run: immediate return to the reset values.

Optional Feature:
- Macro UPS_SEQ_IRQ_EN.
- Defined: adds output port irq (1 bit). irq is sticky-set on the done pulse or on STOP abort, cleared by a CTRL write with IRQ_CLR=1. Set wins over a simultaneous clear. Reset value 0.
- Undefined: no irq port; IRQ_CLR bit ignored.

Decomposition:
- Package ups_pkg:
  - seq_state_t enum {IDLE, LOAD, RUN, DONE}
  - register index constants (REG_CTRL=0, REG_PERIOD=1, REG_COUNT=2, REG_TABLE=3)
  - CTRL bit position constants
- One sub-module: ups_seq_timer (loadable down-counter with zero flag, width TW), instantiated once.

Test Plan:
- N=3, R=0, P=4, table={A,B,C}, START → seq_stb at t+2, t+6, t+10 with seq_out A,B,C; done at t+14; busy low at t+15.
- P=0, N=2, R=1 → 4 strobes on consecutive cycles, values A,B,A,B; one done pulse.
- N=0, START → no seq_stb; done at t+2; seq_out unchanged.
- LOOP=1, N=2, P=3, run 20 cycles, then STOP → strobes continue every 3 cycles until STOP; busy drops next cycle; no done; seq_out holds last value.
- START+STOP in one write → stays IDLE; START while RUN → sequence timing unchanged.
- Assert rst_n=0 asynchronously mid-RUN → outputs 0 immediately; a new START after release behaves like the first scenario. With UPS_SEQ_IRQ_EN: irq sets at done, clears on IRQ_CLR write.
